multicycle_control_unit: RTL and testbench
==========================================

Name: multicycle_control_unit

Overview:
- FSM controller for the multi-cycle RV32I datapath.
- Sequences the shared ALU, the unified instruction/data memory port, IR, MDR, ALUOut and register-file writes over several cycles per instruction.
- Decodes only the IR opcode. ALU function within an instruction comes from the existing ALU control decoder when `alu_ctrl_sel=1`, otherwise forced ADD.
- Sits between IR/bcond/memory-ready and every datapath enable and mux select.

Parameters:
- MEM_WAIT_MAX, 0, max cycles to wait for mem_ready in a memory state; 0 = unlimited.
- STATE_W, 4, width of the state register and `state` debug port.

Ports:
- clk  input  1  clock, all state updates on rising edge
- reset_n  input  1  asynchronous active-low reset
- opcode  input  7  IR[6:0]; valid from the cycle after IF completes
- bcond  input  1  branch-condition result from ALU (valid in EX_BR)
- mem_ready  input  1  memory access completes this cycle
- halt_req  input  1  datapath ECALL halt condition (x17==10)
- pc_write  output  1  PC load enable
- i_or_d  output  1  memory address select: 0 = PC, 1 = ALUOut
- mem_read  output  1  memory read strobe
- mem_write  output  1  memory write strobe
- ir_write  output  1  IR load enable
- mdr_write  output  1  MDR load enable
- alu_out_write  output  1  ALUOut load enable
- reg_write  output  1  register-file write enable
- wb_sel  output  2  write-back source: 00 ALUOut, 01 MDR, 10 live ALU result
- alu_src_a  output  1  ALU A: 0 = PC, 1 = reg A
- alu_src_b  output  2  ALU B: 00 reg B, 01 constant 4, 10 immediate
- alu_ctrl_sel  output  1  0 = force ADD, 1 = funct-decoded op
- pc_source  output  1  0 = live ALU result, 1 = ALUOut
- is_ecall  output  1  high in ECALL state
- is_halted  output  1  high in HALT state
- mem_err  output  1  sticky memory-timeout flag
- state  output  STATE_W  current state (debug)

Behaviour:
- State encodings:
  - IF=0, ID=1, EX_ALU=2, EX_ADDR=3, MEM_RD=4, WB_MEM=5, MEM_WR=6, EX_BR=7
  - EX_JAL=8, EX_JALR=9, JALR_WB=10, WB_ALU=11, PC_INC=12, ECALL=13, HALT=14
  - Encoding 15 is unused and goes to IF.
- Reset:
  - reset_n low → state=IF, mem_err=0 immediately (asynchronous).
  - All outputs forced 0 while reset_n is low, including mid-instruction.
- Unlisted outputs are 0 in each state. Transitions:
  - IF: i_or_d=0, mem_read=1, ir_write=mem_ready. Stay while !mem_ready; on ready → ID.
  - ID: alu_src_a=0, alu_src_b=10, ADD, alu_out_write=1 (ALUOut=PC+imm). Next state by opcode:
    - R/I arithmetic → EX_ALU
    - LOAD/STORE → EX_ADDR
    - BRANCH → EX_BR
    - JAL → EX_JAL
    - JALR → EX_JALR
    - ECALL → ECALL
    - any other opcode → PC_INC (executes as NOP)
  - EX_ALU: alu_src_a=1, alu_src_b=00 (R) or 10 (I), alu_ctrl_sel=1, alu_out_write=1 → WB_ALU.
  - WB_ALU: reg_write=1, wb_sel=00; alu_src_a=0, alu_src_b=01, ADD, pc_write=1, pc_source=0 → IF.
  - EX_ADDR: alu_src_a=1, alu_src_b=10, ADD, alu_out_write=1 → MEM_RD (LOAD) or MEM_WR (STORE).
  - MEM_RD: i_or_d=1, mem_read=1, mdr_write=mem_ready; on ready → WB_MEM.
  - WB_MEM: reg_write=1, wb_sel=01; PC+4 as in WB_ALU → IF.
  - MEM_WR: i_or_d=1, mem_write=1; on ready → PC_INC.
  - EX_BR: alu_src_a=1, alu_src_b=00, alu_ctrl_sel=1.
    - bcond=1: pc_write=1, pc_source=1 → IF.
    - bcond=0: → PC_INC.
  - EX_JAL: ALU=PC+4, reg_write=1, wb_sel=10, pc_write=1, pc_source=1 → IF.
  - EX_JALR: ALU=A+imm, ADD, alu_out_write=1 → JALR_WB.
  - JALR_WB: same outputs as EX_JAL → IF.
  - PC_INC: ALU=PC+4, pc_write=1, pc_source=0 → IF.
  - ECALL: is_ecall=1; halt_req → HALT, else → PC_INC.
  - HALT: is_halted=1, terminal until reset.
- Memory timeout:
  - Wait counter clears on entry to IF, MEM_RD or MEM_WR.
  - If MEM_WAIT_MAX>0 and the counter reaches MEM_WAIT_MAX with !mem_ready: mem_err=1 (sticky), → HALT.
  - mem_ready in the same cycle as the limit wins: normal transition, no error.
- Exactly one pc_write=1 cycle per retired non-halting instruction.
- Cycle counts with mem_ready tied high: R/I 4, branch taken 3, branch not taken 4, load 5, store 5, JAL 3, JALR 4.

Optional Feature:
- Macro `PERF_CNT_EN`.
- Defined:
  - Adds outputs cycle_count[31:0] and retired_count[31:0], both 0 on reset.
  - cycle_count increments every cycle not in HALT.
  - retired_count increments on every pc_write=1 cycle and on HALT entry from ECALL.
  - Both wrap at 2^32.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- ADD (0110011), mem_ready=1 → states 0,1,2,11,0; reg_write and pc_write only in WB_ALU; alu_ctrl_sel=1 only in EX_ALU.
- LOAD (0000011), mem_ready low 3 cycles in MEM_RD → MEM_RD held 4 cycles, mdr_write only on the ready cycle, WB_MEM wb_sel=01.
- BEQ (1100011): bcond=1 → EX_BR pc_write=1, pc_source=1, next IF; bcond=0 → PC_INC, pc_source=0.
- JALR (1100111) → EX_JALR alu_out_write=1, then JALR_WB reg_write=1, wb_sel=10, pc_write=1, pc_source=1.
- ECALL (1110011): halt_req=1 → HALT, is_halted=1 held for 10 cycles; halt_req=0 → PC_INC.
- MEM_WAIT_MAX=4, mem_ready stuck 0 in IF → mem_err=1, HALT after 4 cycles. reset_n pulsed low mid-MEM_RD → state=0, all outputs 0 asynchronously.

Source files
------------

// File: rtl/multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control_unit
// Brief    : Opcode-driven FSM that sequences the multi-cycle RV32I datapath.
//            Optional performance counters are enabled by PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control_unit #(
    parameter int MEM_WAIT_MAX = 0,
    parameter int STATE_W      = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [6:0]         opcode,
    input  logic               bcond,
    input  logic               mem_ready,
    input  logic               halt_req,
    output logic               pc_write,
    output logic               i_or_d,
    output logic               mem_read,
    output logic               mem_write,
    output logic               ir_write,
    output logic               mdr_write,
    output logic               alu_out_write,
    output logic               reg_write,
    output logic [1:0]         wb_sel,
    output logic               alu_src_a,
    output logic [1:0]         alu_src_b,
    output logic               alu_ctrl_sel,
    output logic               pc_source,
    output logic               is_ecall,
    output logic               is_halted,
    output logic               mem_err,
`ifdef PERF_CNT_EN
    output logic [31:0]        cycle_count,
    output logic [31:0]        retired_count,
`endif
    output logic [STATE_W-1:0] state
);

    localparam logic [6:0] c_OP_R      = 7'b0110011;
    localparam logic [6:0] c_OP_I      = 7'b0010011;
    localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] c_OP_STORE  = 7'b0100011;
    localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] c_OP_JAL    = 7'b1101111;
    localparam logic [6:0] c_OP_JALR   = 7'b1100111;
    localparam logic [6:0] c_OP_ECALL  = 7'b1110011;

    typedef enum logic [STATE_W-1:0] {
        S_IF      = STATE_W'(0),
        S_ID      = STATE_W'(1),
        S_EX_ALU  = STATE_W'(2),
        S_EX_ADDR = STATE_W'(3),
        S_MEM_RD  = STATE_W'(4),
        S_WB_MEM  = STATE_W'(5),
        S_MEM_WR  = STATE_W'(6),
        S_EX_BR   = STATE_W'(7),
        S_EX_JAL  = STATE_W'(8),
        S_EX_JALR = STATE_W'(9),
        S_JALR_WB = STATE_W'(10),
        S_WB_ALU  = STATE_W'(11),
        S_PC_INC  = STATE_W'(12),
        S_ECALL   = STATE_W'(13),
        S_HALT    = STATE_W'(14)
    } state_t;

    state_t     r_state;
    state_t     w_state_next;
    logic       r_mem_err;
    logic       w_timeout;

    logic       w_pc_write;
    logic       w_i_or_d;
    logic       w_mem_read;
    logic       w_mem_write;
    logic       w_ir_write;
    logic       w_mdr_write;
    logic       w_alu_out_write;
    logic       w_reg_write;
    logic [1:0] w_wb_sel;
    logic       w_alu_src_a;
    logic [1:0] w_alu_src_b;
    logic       w_alu_ctrl_sel;
    logic       w_pc_source;
    logic       w_is_ecall;
    logic       w_is_halted;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IF;
            r_mem_err <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_timeout) begin
                r_mem_err <= 1'b1;
            end
        end
    end

    always_comb begin
        w_state_next    = r_state;
        w_pc_write      = 1'b0;
        w_i_or_d        = 1'b0;
        w_mem_read      = 1'b0;
        w_mem_write     = 1'b0;
        w_ir_write      = 1'b0;
        w_mdr_write     = 1'b0;
        w_alu_out_write = 1'b0;
        w_reg_write     = 1'b0;
        w_wb_sel        = 2'b00;
        w_alu_src_a     = 1'b0;
        w_alu_src_b     = 2'b00;
        w_alu_ctrl_sel  = 1'b0;
        w_pc_source     = 1'b0;
        w_is_ecall      = 1'b0;
        w_is_halted     = 1'b0;

        case (r_state)
            S_IF: begin
                w_mem_read = 1'b1;
                w_ir_write = mem_ready;
                if (mem_ready)      w_state_next = S_ID;
                else if (w_timeout) w_state_next = S_HALT;
            end
            S_ID: begin
                // Branch/JAL target PC+imm is parked in ALUOut here
                w_alu_src_b     = 2'b10;
                w_alu_out_write = 1'b1;
                case (opcode)
                    c_OP_R, c_OP_I:          w_state_next = S_EX_ALU;
                    c_OP_LOAD, c_OP_STORE:   w_state_next = S_EX_ADDR;
                    c_OP_BRANCH:             w_state_next = S_EX_BR;
                    c_OP_JAL:                w_state_next = S_EX_JAL;
                    c_OP_JALR:               w_state_next = S_EX_JALR;
                    c_OP_ECALL:              w_state_next = S_ECALL;
                    default:                 w_state_next = S_PC_INC;
                endcase
            end
            S_EX_ALU: begin
                w_alu_src_a     = 1'b1;
                w_alu_src_b     = (opcode == c_OP_R) ? 2'b00 : 2'b10;
                w_alu_ctrl_sel  = 1'b1;
                w_alu_out_write = 1'b1;
                w_state_next    = S_WB_ALU;
            end
            S_WB_ALU: begin
                w_reg_write  = 1'b1;
                w_alu_src_b  = 2'b01;
                w_pc_write   = 1'b1;
                w_state_next = S_IF;
            end
            S_EX_ADDR: begin
                w_alu_src_a     = 1'b1;
                w_alu_src_b     = 2'b10;
                w_alu_out_write = 1'b1;
                w_state_next    = (opcode == c_OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                w_i_or_d    = 1'b1;
                w_mem_read  = 1'b1;
                w_mdr_write = mem_ready;
                if (mem_ready)      w_state_next = S_WB_MEM;
                else if (w_timeout) w_state_next = S_HALT;
            end
            S_WB_MEM: begin
                w_reg_write  = 1'b1;
                w_wb_sel     = 2'b01;
                w_alu_src_b  = 2'b01;
                w_pc_write   = 1'b1;
                w_state_next = S_IF;
            end
            S_MEM_WR: begin
                w_i_or_d    = 1'b1;
                w_mem_write = 1'b1;
                if (mem_ready)      w_state_next = S_PC_INC;
                else if (w_timeout) w_state_next = S_HALT;
            end
            S_EX_BR: begin
                w_alu_src_a    = 1'b1;
                w_alu_ctrl_sel = 1'b1;
                if (bcond) begin
                    w_pc_write   = 1'b1;
                    w_pc_source  = 1'b1;
                    w_state_next = S_IF;
                end else begin
                    w_state_next = S_PC_INC;
                end
            end
            S_EX_JAL, S_JALR_WB: begin
                // Link value PC+4 comes live off the ALU; target sits in ALUOut
                w_alu_src_b  = 2'b01;
                w_reg_write  = 1'b1;
                w_wb_sel     = 2'b10;
                w_pc_write   = 1'b1;
                w_pc_source  = 1'b1;
                w_state_next = S_IF;
            end
            S_EX_JALR: begin
                w_alu_src_a     = 1'b1;
                w_alu_src_b     = 2'b10;
                w_alu_out_write = 1'b1;
                w_state_next    = S_JALR_WB;
            end
            S_PC_INC: begin
                w_alu_src_b  = 2'b01;
                w_pc_write   = 1'b1;
                w_state_next = S_IF;
            end
            S_ECALL: begin
                w_is_ecall   = 1'b1;
                w_state_next = halt_req ? S_HALT : S_PC_INC;
            end
            S_HALT: begin
                w_is_halted = 1'b1;
            end
            default: begin
                w_state_next = S_IF;
            end
        endcase
    end

    generate
        if (MEM_WAIT_MAX > 0) begin : g_timeout
            localparam int c_CNT_W = (MEM_WAIT_MAX > 2) ? $clog2(MEM_WAIT_MAX) : 1;
            localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(MEM_WAIT_MAX - 1);

            logic [c_CNT_W-1:0] r_wait_cnt;
            logic               w_mem_state;

            assign w_mem_state = (r_state == S_IF) || (r_state == S_MEM_RD) ||
                                 (r_state == S_MEM_WR);

            // Counts cycles already spent in the current memory state
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_wait_cnt <= '0;
                end else if ((w_state_next != r_state) || !w_mem_state) begin
                    r_wait_cnt <= '0;
                end else if (r_wait_cnt != c_LIMIT) begin
                    r_wait_cnt <= r_wait_cnt + c_CNT_W'(1);
                end
            end

            assign w_timeout = w_mem_state && !mem_ready && (r_wait_cnt == c_LIMIT);
        end else begin : g_no_timeout
            assign w_timeout = 1'b0;
        end
    endgenerate

`ifdef PERF_CNT_EN
    logic [31:0] r_cycle_count;
    logic [31:0] r_retired_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cycle_count   <= '0;
            r_retired_count <= '0;
        end else begin
            if (r_state != S_HALT) begin
                r_cycle_count <= r_cycle_count + 32'd1;
            end
            if (w_pc_write || ((r_state == S_ECALL) && (w_state_next == S_HALT))) begin
                r_retired_count <= r_retired_count + 32'd1;
            end
        end
    end

    assign cycle_count   = r_cycle_count;
    assign retired_count = r_retired_count;
`endif

    // Every control strobe is held low while reset is asserted
    assign pc_write      = w_pc_write      & reset_n;
    assign i_or_d        = w_i_or_d        & reset_n;
    assign mem_read      = w_mem_read      & reset_n;
    assign mem_write     = w_mem_write     & reset_n;
    assign ir_write      = w_ir_write      & reset_n;
    assign mdr_write     = w_mdr_write     & reset_n;
    assign alu_out_write = w_alu_out_write & reset_n;
    assign reg_write     = w_reg_write     & reset_n;
    assign wb_sel        = w_wb_sel        & {2{reset_n}};
    assign alu_src_a     = w_alu_src_a     & reset_n;
    assign alu_src_b     = w_alu_src_b     & {2{reset_n}};
    assign alu_ctrl_sel  = w_alu_ctrl_sel  & reset_n;
    assign pc_source     = w_pc_source     & reset_n;
    assign is_ecall      = w_is_ecall      & reset_n;
    assign is_halted     = w_is_halted     & reset_n;
    assign mem_err       = r_mem_err       & reset_n;
    assign state         = r_state;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control_unit
// Brief    : Directed self-checking bench for multicycle_control_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control_unit;

    // Control vector layout:
    // {pc_write,i_or_d,mem_read,mem_write,ir_write,mdr_write,alu_out_write,reg_write}
    // _ wb_sel _ alu_src_a _ alu_src_b _ {alu_ctrl_sel,pc_source,is_ecall,is_halted,mem_err}
    localparam logic [17:0] c_ZERO     = 18'b00000000_00_0_00_00000;
    localparam logic [17:0] c_IF_RDY   = 18'b00101000_00_0_00_00000;
    localparam logic [17:0] c_IF_WAIT  = 18'b00100000_00_0_00_00000;
    localparam logic [17:0] c_ID       = 18'b00000010_00_0_10_00000;
    localparam logic [17:0] c_EX_R     = 18'b00000010_00_1_00_10000;
    localparam logic [17:0] c_EX_I     = 18'b00000010_00_1_10_10000;
    localparam logic [17:0] c_WB_ALU   = 18'b10000001_00_0_01_00000;
    localparam logic [17:0] c_EX_ADDR  = 18'b00000010_00_1_10_00000;
    localparam logic [17:0] c_RD_WAIT  = 18'b01100000_00_0_00_00000;
    localparam logic [17:0] c_RD_RDY   = 18'b01100100_00_0_00_00000;
    localparam logic [17:0] c_WB_MEM   = 18'b10000001_01_0_01_00000;
    localparam logic [17:0] c_MEM_WR   = 18'b01010000_00_0_00_00000;
    localparam logic [17:0] c_PC_INC   = 18'b10000000_00_0_01_00000;
    localparam logic [17:0] c_BR_TAKEN = 18'b10000000_00_1_00_11000;
    localparam logic [17:0] c_BR_NOT   = 18'b00000000_00_1_00_10000;
    localparam logic [17:0] c_JAL_WB   = 18'b10000001_10_0_01_01000;
    localparam logic [17:0] c_EX_JALR  = 18'b00000010_00_1_10_00000;
    localparam logic [17:0] c_ECALL    = 18'b00000000_00_0_00_00100;
    localparam logic [17:0] c_HALT     = 18'b00000000_00_0_00_00010;
    localparam logic [17:0] c_HALT_ERR = 18'b00000000_00_0_00_00011;

    logic        clk;
    logic        reset_n;
    logic [6:0]  opcode;
    logic        bcond;
    logic        mem_ready;
    logic        halt_req;
    logic        pc_write;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        ir_write;
    logic        mdr_write;
    logic        alu_out_write;
    logic        reg_write;
    logic [1:0]  wb_sel;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic        alu_ctrl_sel;
    logic        pc_source;
    logic        is_ecall;
    logic        is_halted;
    logic        mem_err;
    logic [3:0]  state;
`ifdef PERF_CNT_EN
    logic [31:0] cycle_count;
    logic [31:0] retired_count;
`endif
    logic [17:0] ctl;

    int n_checks = 0;
    int n_errors = 0;

    multicycle_control_unit #(
        .MEM_WAIT_MAX (4),
        .STATE_W      (4)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .opcode        (opcode),
        .bcond         (bcond),
        .mem_ready     (mem_ready),
        .halt_req      (halt_req),
        .pc_write      (pc_write),
        .i_or_d        (i_or_d),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .ir_write      (ir_write),
        .mdr_write     (mdr_write),
        .alu_out_write (alu_out_write),
        .reg_write     (reg_write),
        .wb_sel        (wb_sel),
        .alu_src_a     (alu_src_a),
        .alu_src_b     (alu_src_b),
        .alu_ctrl_sel  (alu_ctrl_sel),
        .pc_source     (pc_source),
        .is_ecall      (is_ecall),
        .is_halted     (is_halted),
        .mem_err       (mem_err),
`ifdef PERF_CNT_EN
        .cycle_count   (cycle_count),
        .retired_count (retired_count),
`endif
        .state         (state)
    );

    assign ctl = {pc_write, i_or_d, mem_read, mem_write, ir_write, mdr_write,
                  alu_out_write, reg_write, wb_sel, alu_src_a, alu_src_b,
                  alu_ctrl_sel, pc_source, is_ecall, is_halted, mem_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, act, exp);
        end
    endtask

    // Drive inputs for one cycle, check mid-cycle, then advance past the edge
    task automatic step(input string tag, input logic rdy, input logic bc, input logic hr,
                        input int exp_state, input logic [17:0] exp_ctl);
        mem_ready = rdy;
        bcond     = bc;
        halt_req  = hr;
        #1;
        check({tag, "_state"}, 32'(state), 32'(exp_state));
        check({tag, "_ctl"}, 32'(ctl), 32'(exp_ctl));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        check({tag, "_rst_state"}, 32'(state), 32'd0);
        check({tag, "_rst_ctl"}, 32'(ctl), 32'(c_ZERO));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n   = 1'b0;
        opcode    = 7'b0000000;
        bcond     = 1'b0;
        mem_ready = 1'b0;
        halt_req  = 1'b0;
        #2;
        do_reset("por");

        // ADD
        opcode = 7'b0110011;
        step("add_if",   1, 0, 0,  0, c_IF_RDY);
        step("add_id",   1, 0, 0,  1, c_ID);
        step("add_ex",   1, 0, 0,  2, c_EX_R);
        step("add_wb",   1, 0, 0, 11, c_WB_ALU);

        // ADDI
        opcode = 7'b0010011;
        step("addi_if",  1, 0, 0,  0, c_IF_RDY);
        step("addi_id",  1, 0, 0,  1, c_ID);
        step("addi_ex",  1, 0, 0,  2, c_EX_I);
        step("addi_wb",  1, 0, 0, 11, c_WB_ALU);

        // LOAD, three wait cycles; ready arrives exactly at the timeout limit
        opcode = 7'b0000011;
        step("ld_if",    1, 0, 0,  0, c_IF_RDY);
        step("ld_id",    1, 0, 0,  1, c_ID);
        step("ld_addr",  1, 0, 0,  3, c_EX_ADDR);
        for (int i = 0; i < 3; i++) begin
            step("ld_wait", 0, 0, 0, 4, c_RD_WAIT);
        end
        step("ld_rdy",   1, 0, 0,  4, c_RD_RDY);
        step("ld_wb",    1, 0, 0,  5, c_WB_MEM);

        // STORE
        opcode = 7'b0100011;
        step("st_if",    1, 0, 0,  0, c_IF_RDY);
        step("st_id",    1, 0, 0,  1, c_ID);
        step("st_addr",  1, 0, 0,  3, c_EX_ADDR);
        step("st_wr",    1, 0, 0,  6, c_MEM_WR);
        step("st_inc",   1, 0, 0, 12, c_PC_INC);

        // BEQ taken, then not taken
        opcode = 7'b1100011;
        step("bt_if",    1, 0, 0,  0, c_IF_RDY);
        step("bt_id",    1, 0, 0,  1, c_ID);
        step("bt_ex",    1, 1, 0,  7, c_BR_TAKEN);
        step("bn_if",    1, 0, 0,  0, c_IF_RDY);
        step("bn_id",    1, 0, 0,  1, c_ID);
        step("bn_ex",    1, 0, 0,  7, c_BR_NOT);
        step("bn_inc",   1, 0, 0, 12, c_PC_INC);

        // JAL
        opcode = 7'b1101111;
        step("jal_if",   1, 0, 0,  0, c_IF_RDY);
        step("jal_id",   1, 0, 0,  1, c_ID);
        step("jal_ex",   1, 0, 0,  8, c_JAL_WB);

        // JALR
        opcode = 7'b1100111;
        step("jalr_if",  1, 0, 0,  0, c_IF_RDY);
        step("jalr_id",  1, 0, 0,  1, c_ID);
        step("jalr_ex",  1, 0, 0,  9, c_EX_JALR);
        step("jalr_wb",  1, 0, 0, 10, c_JAL_WB);

        // LUI is not decoded: behaves as a NOP
        opcode = 7'b0110111;
        step("nop_if",   1, 0, 0,  0, c_IF_RDY);
        step("nop_id",   1, 0, 0,  1, c_ID);
        step("nop_inc",  1, 0, 0, 12, c_PC_INC);

        // ECALL without halt, then with halt
        opcode = 7'b1110011;
        step("ec_if",    1, 0, 0,  0, c_IF_RDY);
        step("ec_id",    1, 0, 0,  1, c_ID);
        step("ec_ex",    1, 0, 0, 13, c_ECALL);
        step("ec_inc",   1, 0, 0, 12, c_PC_INC);
        step("eh_if",    1, 0, 0,  0, c_IF_RDY);
        step("eh_id",    1, 0, 0,  1, c_ID);
        step("eh_ex",    1, 0, 1, 13, c_ECALL);
        for (int i = 0; i < 10; i++) begin
            step("halt", 1, 0, 0, 14, c_HALT);
        end
        do_reset("after_halt");

        // Fetch never completes: four IF cycles, then HALT with mem_err
        for (int i = 0; i < 4; i++) begin
            step("to_if", 0, 0, 0, 0, c_IF_WAIT);
        end
        for (int i = 0; i < 3; i++) begin
            step("to_halt", 0, 0, 0, 14, c_HALT_ERR);
        end
        do_reset("after_err");

        // Reset asserted in the middle of a load wait
        opcode = 7'b0000011;
        step("mr_if",    1, 0, 0,  0, c_IF_RDY);
        step("mr_id",    1, 0, 0,  1, c_ID);
        step("mr_addr",  1, 0, 0,  3, c_EX_ADDR);
        step("mr_wait",  0, 0, 0,  4, c_RD_WAIT);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_state", 32'(state), 32'd0);
        check("mid_rst_ctl", 32'(ctl), 32'(c_ZERO));
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step("post_rst_if", 1, 0, 0, 0, c_IF_RDY);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
